// File: rtl/axi_burst_slave.sv
// AXI4 burst slave over a word-addressed register array with FIXED/INCR/WRAP bursts,
// byte strobes, range checking and SLVERR responses; read and write channels are independent.
module axi_burst_slave #(
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                a_clk,
    input  logic                a_rst,
    input  logic [ADDR_W-1:0]   a_awaddr,
    input  logic                a_awvalid,
    output logic                a_awready,
    input  logic [7:0]          a_awlen,
    input  logic [2:0]          a_awsize,
    input  logic [1:0]          a_awburst,
    input  logic                a_wvalid,
    output logic                a_wready,
    input  logic                a_wlast,
    input  logic [DATA_W-1:0]   a_wdata,
    input  logic [DATA_W/8-1:0] a_wstrb,
    output logic                a_bvalid,
    input  logic                a_bready,
    output logic [1:0]          a_bresp,
    input  logic                a_arvalid,
    output logic                a_arready,
    input  logic [ADDR_W-1:0]   a_araddr,
    input  logic [7:0]          a_arlen,
    input  logic [2:0]          a_arsize,
    input  logic [1:0]          a_arburst,
    output logic                a_rvalid,
    input  logic                a_rready,
    output logic                a_rlast,
    output logic [DATA_W-1:0]   a_rdata,
    output logic [1:0]          a_rresp
);
    localparam int unsigned       BYTES = DATA_W / 8;
    localparam int unsigned       LB    = $clog2(BYTES);
    localparam int unsigned       IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * BYTES);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size,
                                       input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == 2'b11) || (32'(size) > LB) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    // WRAP keeps the upper bits of the (len+1)<<size aligned window and wraps the lower ones
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [7:0] len,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] mask;
        step = ADDR_W'(1) << size;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~mask) | ((addr + step) & mask);
            default: return addr + step;
        endcase
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return (addr - BASE_ADDR) < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> LB);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    w_state_t          w_state;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len, w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic              w_err, w_berr;
    logic              w_fire, w_beat_ok, w_beat_err, w_final;

    r_state_t          r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len, r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic              r_berr, ar_berr;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_ok;
    logic [DATA_W-1:0] ld_data;

    always_comb begin
        w_fire     = (w_state == W_DATA) && a_wready && a_wvalid;
        w_beat_ok  = !w_berr && in_range(w_addr);
        w_final    = (w_cnt == w_len);
        w_beat_err = !w_beat_ok || (a_wlast != w_final);
    end

    // Read beat source: the AR address at handshake, the running burst address afterwards
    always_comb begin
        ar_berr = burst_err(a_arburst, a_arsize, a_arlen);
        ld_addr = (r_state == R_IDLE) ? a_araddr : r_addr;
        ld_ok   = ((r_state == R_IDLE) ? !ar_berr : !r_berr) && in_range(ld_addr);
        ld_data = ld_ok ? mem[word_idx(ld_addr)] : '0;
    end

    // Array is deliberately not reset
    always_ff @(posedge a_clk) begin
        if (!a_rst && w_fire && w_beat_ok) begin
            for (int b = 0; b < BYTES; b++) begin
                if (a_wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= a_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            w_state   <= W_IDLE;
            a_awready <= 1'b0;
            a_wready  <= 1'b0;
            a_bvalid  <= 1'b0;
            a_bresp   <= 2'b00;
            w_addr    <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_size    <= '0;
            w_burst   <= '0;
            w_err     <= 1'b0;
            w_berr    <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (a_awvalid && a_awready) begin
                        w_addr    <= a_awaddr;
                        w_len     <= a_awlen;
                        w_size    <= a_awsize;
                        w_burst   <= a_awburst;
                        w_berr    <= burst_err(a_awburst, a_awsize, a_awlen);
                        w_err     <= 1'b0;
                        w_cnt     <= '0;
                        a_awready <= 1'b0;
                        a_wready  <= 1'b1;
                        w_state   <= W_DATA;
                    end else begin
                        a_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                        w_cnt  <= w_cnt + 8'd1;
                        w_err  <= w_err || w_beat_err;
                        if (w_final) begin
                            a_wready <= 1'b0;
                            a_bvalid <= 1'b1;
                            a_bresp  <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
                            w_state  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (a_bready) begin
                        a_bvalid  <= 1'b0;
                        a_bresp   <= 2'b00;
                        a_awready <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            r_state   <= R_IDLE;
            a_arready <= 1'b0;
            a_rvalid  <= 1'b0;
            a_rlast   <= 1'b0;
            a_rdata   <= '0;
            a_rresp   <= 2'b00;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_berr    <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (a_arvalid && a_arready) begin
                        r_len     <= a_arlen;
                        r_size    <= a_arsize;
                        r_burst   <= a_arburst;
                        r_berr    <= ar_berr;
                        r_addr    <= next_addr(a_araddr, a_arlen, a_arsize, a_arburst);
                        r_cnt     <= '0;
                        a_arready <= 1'b0;
                        a_rvalid  <= 1'b1;
                        a_rlast   <= (a_arlen == 8'd0);
                        a_rdata   <= ld_data;
                        a_rresp   <= ld_ok ? 2'b00 : 2'b10;
                        r_state   <= R_DATA;
                    end else begin
                        a_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (a_rready) begin
                        if (a_rlast) begin
                            a_rvalid  <= 1'b0;
                            a_rlast   <= 1'b0;
                            a_rresp   <= 2'b00;
                            a_arready <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            a_rdata <= ld_data;
                            a_rresp <= ld_ok ? 2'b00 : 2'b10;
                            a_rlast <= ((r_cnt + 8'd1) == r_len);
                            r_cnt   <= r_cnt + 8'd1;
                            r_addr  <= next_addr(r_addr, r_len, r_size, r_burst);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule
